uart_cfg: RTL and testbench
===========================

Name: uart_cfg

Overview:
Next-generation UART for the serial link path: baud generator, 16x-oversampled receiver, transmitter and independent RX/TX FIFOs in one block. The baud divisor, parity and stop-bit count are runtime-programmable. RX words carry per-word parity/framing error flags, and a sticky overrun flag is provided. It sits between the pad-level rx/tx pins and the byte-stream consumers/producers in the core.

Parameters:
DBIT, 8, data bits per frame (5..8)
DVSR_BIT, 11, width of runtime divisor input dvsr
RX_FIFO_W, 2, RX FIFO address bits; depth 2^RX_FIFO_W
TX_FIFO_W, 10, TX FIFO address bits; depth 2^TX_FIFO_W

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low
dvsr  in  DVSR_BIT  baud tick period in clk cycles; dvsr = f_clk/(16*baud)
par_mode  in  2  00 none, 01 even, 10 odd, 11 none
stop2  in  1  0: 1 stop bit (16 ticks), 1: 2 stop bits (32 ticks)
rx  in  1  serial input (synchronised internally, 2 flops)
rd_uart  in  1  pop RX FIFO head
wr_uart  in  1  push w_data into TX FIFO
w_data  in  DBIT  TX byte
clr_err  in  1  clears rx_ovf
r_data  out  DBIT  RX FIFO head (first-word fall-through)
r_perr  out  1  parity error flag of head word
r_ferr  out  1  framing error flag of head word
rx_empty  out  1  RX FIFO empty
rx_ovf  out  1  sticky: received word dropped because RX FIFO was full
tx_full  out  1  TX FIFO full
tx_idle  out  1  TX FIFO empty and transmitter idle
tx  out  1  serial output

Behaviour:
- Reset (reset=0, async): tx=1, rx_empty=1, tx_full=0, tx_idle=1, rx_ovf=0, r_data/r_perr/r_ferr=0. FIFOs are emptied, FSMs go to IDLE and the baud counter goes to 0. A frame in flight is aborted, and tx returns to 1 immediately.
- Baud gen: the counter runs 0..dvsr-1, and a tick pulses for one clk at dvsr-1. dvsr<2 holds the counter at 0 with no ticks, which freezes both FSMs. If dvsr decreases while count>=dvsr-1, the counter wraps to 0 on the next clk with no tick.
- par_mode and stop2 are latched per frame: at start-bit detect (RX) and at leaving IDLE (TX).
- RX FSM: IDLE -> START -> DATA -> PARITY (only if parity enabled) -> STOP -> IDLE.
  - IDLE -> START on synchronised rx=0.
  - START: the line is sampled at tick 7. If it is 1, the start is false and the FSM returns to IDLE.
  - DATA: each bit is sampled at mid-bit (every 16 ticks), LSB first.
  - PARITY: sampled mid-bit and compared with the computed even/odd parity; mismatch sets perr.
  - STOP: the first stop bit is sampled mid-bit; a 0 sets ferr. When stop2=1, the FSM waits 32 ticks total but checks only the first stop bit.
  - At STOP end, {ferr,perr,data} is pushed in the same clk. The word is pushed even when errors are set.
- RX overrun: a push while the RX FIFO is full drops the word and sets rx_ovf. rx_ovf stays set until clr_err=1. If clr_err coincides with an overrun, rx_ovf ends set (set wins).
- TX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - It leaves IDLE on the first tick with the TX FIFO non-empty.
  - The head is popped and latched on entering START; tx=0 for 16 ticks.
  - DATA sends the data LSB first, 16 ticks per bit, then the parity bit if enabled, then tx=1 for 16 or 32 ticks.
  - A back-to-back frame starts on the tick after STOP ends.
  - tx_idle=1 only in IDLE with the TX FIFO empty.
- FIFOs: first-word fall-through, registered flags.
  - rd while empty and wr while full are ignored, and no state changes.
  - Simultaneous rd+wr when full: both are performed and the FIFO stays full.
  - Simultaneous rd+wr when empty: the write is performed and the read ignored.
  - Pointers wrap modulo 2^W.
- Width rule: the RX FIFO word is DBIT+2 bits. Parity is computed over DBIT bits only.

Optional Feature:
UART_LOOPBACK_EN: when defined, adds input port loopback (1 bit).
- With loopback=1, the RX synchroniser input is the internal tx signal, and the tx pin is held at 1.
- With loopback=0, or when the macro is undefined, rx is fed from the pin and the port does not exist.

Test Plan:
- dvsr=4, par_mode=00, stop2=0, write 0xA5 -> tx low for 64 clk, then bits 1,0,1,0,0,1,0,1 at 64 clk each, then high. tx_idle returns 1 after 640 clk plus at most 4 clk of start alignment.
- dvsr=4, par_mode=01, drive rx frame 0x07 with parity bit 1 -> RX word 0x07 with perr=0. Repeat with parity bit 0 -> perr=1.
- Drive rx frame 0x3C with stop bit 0 -> word 0x3C pushed, r_ferr=1, rx_empty=0.
- RX_FIFO_W=2: receive 5 frames without rd_uart -> 4 words kept in order and the 5th dropped. rx_ovf=1 until a clr_err pulse, then 0.
- UART_LOOPBACK_EN, loopback=1, par_mode=10, stop2=1: write 0x00, 0xFF, 0x5A -> same bytes read back in order with no error flags, tx pin constant 1.
- Assert reset mid-DATA of a TX frame and mid-DATA of an RX frame -> tx=1 immediately, all flags at reset values. The next frame is received and transmitted correctly.

Source files
------------

// File: rtl/uart_cfg_if.sv
// uart_cfg_if: byte-stream side of uart_cfg.
// Covers RX/TX FIFO access and status flags.
interface uart_cfg_if #(
  parameter int DBIT = 8
);
  logic            rd_uart;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic            clr_err;
  logic [DBIT-1:0] r_data;
  logic            r_perr;
  logic            r_ferr;
  logic            rx_empty;
  logic            rx_ovf;
  logic            tx_full;
  logic            tx_idle;

  modport master (
    output rd_uart, wr_uart, w_data, clr_err,
    input  r_data, r_perr, r_ferr, rx_empty,
    input  rx_ovf, tx_full, tx_idle
  );

  modport slave (
    input  rd_uart, wr_uart, w_data, clr_err,
    output r_data, r_perr, r_ferr, rx_empty,
    output rx_ovf, tx_full, tx_idle
  );
endinterface

// File: rtl/uart_cfg.sv
// uart_cfg: baud gen, 16x RX, TX, RX/TX FWFT FIFOs.
// Define UART_LOOPBACK_EN to add the loopback port (tx fed into RX).
module uart_cfg_fifo #(
  parameter int W  = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_empty,
  output logic          o_full
);
  logic [DW-1:0] r_mem [2**W];
  logic [W-1:0]  r_wp, r_rp;
  logic [W-1:0]  w_wp1, w_rp1;
  logic          r_empty, r_full;
  logic          w_wr, w_rd;

  // a read frees a slot, so a full FIFO still accepts a same-cycle write
  assign w_rd  = i_rd && !r_empty;
  assign w_wr  = i_wr && (!r_full || i_rd);
  assign w_wp1 = r_wp + 1'b1;
  assign w_rp1 = r_rp + 1'b1;

  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= i_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_wr) r_wp <= w_wp1;
      if (w_rd) r_rp <= w_rp1;
      case ({w_wr, w_rd})
        2'b10: begin
          r_empty <= 1'b0;
          r_full  <= (w_wp1 == r_rp);
        end
        2'b01: begin
          r_full  <= 1'b0;
          r_empty <= (w_rp1 == r_wp);
        end
        default: ;
      endcase
    end
  end

  assign o_data  = r_mem[r_rp];
  assign o_empty = r_empty;
  assign o_full  = r_full;
endmodule

module uart_cfg #(
  parameter int DBIT      = 8,
  parameter int DVSR_BIT  = 11,
  parameter int RX_FIFO_W = 2,
  parameter int TX_FIFO_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic [1:0]          par_mode,
  input  logic                stop2,
  input  logic                rx,
`ifdef UART_LOOPBACK_EN
  input  logic                loopback,
`endif
  output logic                tx,
  uart_cfg_if.slave           bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  logic [DVSR_BIT-1:0] r_cnt;
  logic                w_run, w_tick;
  logic [1:0]          r_sync;
  logic                w_rx_in, w_rx_s;
  logic                r_tx;

  assign w_run  = dvsr > DVSR_BIT'(1);
  assign w_tick = w_run && (r_cnt == dvsr - 1'b1);

  // a shrinking dvsr can leave r_cnt above the terminal value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cnt <= '0;
    else if (!w_run || r_cnt >= dvsr - 1'b1)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

`ifdef UART_LOOPBACK_EN
  assign w_rx_in = loopback ? r_tx : rx;
  assign tx      = loopback ? 1'b1 : r_tx;
`else
  assign w_rx_in = rx;
  assign tx      = r_tx;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], w_rx_in};
  end
  assign w_rx_s = r_sync[1];

  state_t            r_rx_st;
  logic [4:0]        r_rx_s;
  logic [2:0]        r_rx_n;
  logic [DBIT-1:0]   r_rx_b;
  logic [1:0]        r_rx_pm;
  logic              r_rx_st2, r_rx_perr, r_rx_ferr;
  logic              w_rx_mid, w_rx_end, w_rx_push;
  logic              w_rx_ferr, w_rx_pexp, w_rx_pen;
  logic [DBIT+1:0]   w_rx_head;
  logic              w_rx_empty, w_rx_full;
  logic              r_ovf;

  assign w_rx_mid  = r_rx_s == 5'd15;
  assign w_rx_end  = r_rx_s == (r_rx_st2 ? 5'd31 : 5'd15);
  assign w_rx_push = (r_rx_st == S_STOP) && w_tick && w_rx_end;
  assign w_rx_ferr = w_rx_mid ? !w_rx_s : r_rx_ferr;
  assign w_rx_pen  = ^r_rx_pm;
  assign w_rx_pexp = r_rx_pm[1] ? ~^r_rx_b : ^r_rx_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_st   <= S_IDLE;
      r_rx_s    <= '0;
      r_rx_n    <= '0;
      r_rx_b    <= '0;
      r_rx_pm   <= '0;
      r_rx_st2  <= 1'b0;
      r_rx_perr <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else begin
      unique case (r_rx_st)
        S_IDLE: if (!w_rx_s) begin
          r_rx_st   <= S_START;
          r_rx_s    <= '0;
          r_rx_pm   <= par_mode;
          r_rx_st2  <= stop2;
          r_rx_perr <= 1'b0;
          r_rx_ferr <= 1'b0;
        end
        S_START: if (w_tick) begin
          if (r_rx_s == 5'd7) begin
            r_rx_s  <= '0;
            r_rx_n  <= '0;
            r_rx_st <= w_rx_s ? S_IDLE : S_DATA;
          end else r_rx_s <= r_rx_s + 1'b1;
        end
        S_DATA: if (w_tick) begin
          if (w_rx_mid) begin
            r_rx_s <= '0;
            r_rx_n <= r_rx_n + 1'b1;
            r_rx_b <= {w_rx_s, r_rx_b[DBIT-1:1]};
            if (r_rx_n == 3'(DBIT-1))
              r_rx_st <= w_rx_pen ? S_PAR : S_STOP;
          end else r_rx_s <= r_rx_s + 1'b1;
        end
        S_PAR: if (w_tick) begin
          if (w_rx_mid) begin
            r_rx_s    <= '0;
            r_rx_perr <= w_rx_s != w_rx_pexp;
            r_rx_st   <= S_STOP;
          end else r_rx_s <= r_rx_s + 1'b1;
        end
        S_STOP: if (w_tick) begin
          if (w_rx_mid) r_rx_ferr <= !w_rx_s;
          if (w_rx_end) r_rx_st <= S_IDLE;
          else          r_rx_s  <= r_rx_s + 1'b1;
        end
        default: r_rx_st <= S_IDLE;
      endcase
    end
  end

  uart_cfg_fifo #(.W(RX_FIFO_W), .DW(DBIT+2)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_wr    (w_rx_push),
    .i_rd    (bus.rd_uart),
    .i_data  ({w_rx_ferr, r_rx_perr, r_rx_b}),
    .o_data  (w_rx_head),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_ovf <= 1'b0;
    else if (w_rx_push && w_rx_full && !bus.rd_uart)
      r_ovf <= 1'b1;
    else if (bus.clr_err)
      r_ovf <= 1'b0;
  end

  assign bus.r_data   = w_rx_empty ? '0 : w_rx_head[DBIT-1:0];
  assign bus.r_perr   = !w_rx_empty && w_rx_head[DBIT];
  assign bus.r_ferr   = !w_rx_empty && w_rx_head[DBIT+1];
  assign bus.rx_empty = w_rx_empty;
  assign bus.rx_ovf   = r_ovf;

  state_t            r_tx_st;
  logic [4:0]        r_tx_s;
  logic [2:0]        r_tx_n;
  logic [DBIT-1:0]   r_tx_b;
  logic              r_tx_pen, r_tx_pbit, r_tx_st2;
  logic              w_tx_pop, w_tx_empty, w_tx_full;
  logic [DBIT-1:0]   w_tx_head;

  assign w_tx_pop = (r_tx_st == S_IDLE) && w_tick && !w_tx_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_st   <= S_IDLE;
      r_tx_s    <= '0;
      r_tx_n    <= '0;
      r_tx_b    <= '0;
      r_tx_pen  <= 1'b0;
      r_tx_pbit <= 1'b0;
      r_tx_st2  <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      unique case (r_tx_st)
        S_IDLE: if (w_tx_pop) begin
          r_tx_st   <= S_START;
          r_tx_s    <= '0;
          r_tx_b    <= w_tx_head;
          r_tx_pen  <= ^par_mode;
          r_tx_pbit <= par_mode[1] ? ~^w_tx_head : ^w_tx_head;
          r_tx_st2  <= stop2;
          r_tx      <= 1'b0;
        end
        S_START: if (w_tick) begin
          if (r_tx_s == 5'd15) begin
            r_tx_s  <= '0;
            r_tx_n  <= '0;
            r_tx_st <= S_DATA;
            r_tx    <= r_tx_b[0];
          end else r_tx_s <= r_tx_s + 1'b1;
        end
        S_DATA: if (w_tick) begin
          if (r_tx_s == 5'd15) begin
            r_tx_s <= '0;
            r_tx_n <= r_tx_n + 1'b1;
            r_tx_b <= {1'b0, r_tx_b[DBIT-1:1]};
            if (r_tx_n == 3'(DBIT-1)) begin
              r_tx_st <= r_tx_pen ? S_PAR : S_STOP;
              r_tx    <= r_tx_pen ? r_tx_pbit : 1'b1;
            end else r_tx <= r_tx_b[1];
          end else r_tx_s <= r_tx_s + 1'b1;
        end
        S_PAR: if (w_tick) begin
          if (r_tx_s == 5'd15) begin
            r_tx_s  <= '0;
            r_tx_st <= S_STOP;
            r_tx    <= 1'b1;
          end else r_tx_s <= r_tx_s + 1'b1;
        end
        S_STOP: if (w_tick) begin
          if (r_tx_s == (r_tx_st2 ? 5'd31 : 5'd15))
            r_tx_st <= S_IDLE;
          else
            r_tx_s <= r_tx_s + 1'b1;
        end
        default: r_tx_st <= S_IDLE;
      endcase
    end
  end

  uart_cfg_fifo #(.W(TX_FIFO_W), .DW(DBIT)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_wr    (bus.wr_uart),
    .i_rd    (w_tx_pop),
    .i_data  (bus.w_data),
    .o_data  (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full)
  );

  assign bus.tx_full = w_tx_full;
  assign bus.tx_idle = (r_tx_st == S_IDLE) && w_tx_empty;
endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: scoreboard bench for uart_cfg at dvsr=4 (64 clk/bit).
// Define UART_LOOPBACK_EN to also cover the loopback path.
`timescale 1ns/1ps
module tb_uart_cfg;
  localparam int BITC = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] dvsr = 11'd4;
  logic [1:0]  par_mode = 2'b00;
  logic        stop2 = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
`ifdef UART_LOOPBACK_EN
  logic        loopback = 1'b0;
  logic        lb_watch = 1'b0;
  int          lb_low = 0;
`endif

  int         checks = 0;
  int         failures = 0;
  logic       exp_ovf = 1'b0;
  logic [9:0] rxq[$];
  logic [7:0] txq[$];

  uart_cfg_if #(.DBIT(8)) bus();

  uart_cfg #(
    .DBIT(8), .DVSR_BIT(11), .RX_FIFO_W(2), .TX_FIFO_W(10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dvsr     (dvsr),
    .par_mode (par_mode),
    .stop2    (stop2),
    .rx       (rx),
`ifdef UART_LOOPBACK_EN
    .loopback (loopback),
`endif
    .tx       (tx),
    .bus      (bus)
  );

  always #5 clk = ~clk;

`ifdef UART_LOOPBACK_EN
  always @(negedge clk)
    if (lb_watch && tx !== 1'b1) lb_low++;
`endif

  task automatic apply_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d, input bit track);
    if (track) txq.push_back(d);
    bus.w_data  = d;
    bus.wr_uart = 1'b1;
    @(negedge clk);
    bus.wr_uart = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] d, input bit pbit,
                          input bit stopv);
    logic pe;
    logic pexp;
    pexp = (par_mode == 2'b10) ? ~(^d) : ^d;
    pe   = (^par_mode) && (pbit != pexp);
    if (rxq.size() < 4) rxq.push_back({~stopv, pe, d});
    else exp_ovf = 1'b1;
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BITC) @(negedge clk);
    end
    if (^par_mode) begin
      rx = pbit;
      repeat (BITC) @(negedge clk);
    end
    if (stopv) begin
      rx = 1'b1;
      repeat (stop2 ? 2 * BITC : BITC) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (BITC * 3 / 4) @(negedge clk);
      rx = 1'b1;
      repeat (BITC) @(negedge clk);
    end
    repeat (16) @(negedge clk);
  endtask

  task automatic read_rx(output logic [9:0] w, output bit ok);
    int n = 0;
    while (bus.rx_empty !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.rx_empty === 1'b0);
    w  = {bus.r_ferr, bus.r_perr, bus.r_data};
    if (ok) begin
      bus.rd_uart = 1'b1;
      @(negedge clk);
      bus.rd_uart = 1'b0;
    end
  endtask

  task automatic tx_capture(output logic st, output logic [7:0] d,
                            output logic pb, output logic sp,
                            output bit ok);
    int n = 0;
    st = 1'b1; d = '0; pb = 1'b0; sp = 1'b0;
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = (tx === 1'b0);
    if (!ok) return;
    repeat (BITC / 2) @(negedge clk);
    st = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (BITC) @(negedge clk);
      d[i] = tx;
    end
    if (^par_mode) begin
      repeat (BITC) @(negedge clk);
      pb = tx;
    end
    repeat (BITC) @(negedge clk);
    sp = tx;
    if (stop2) begin
      repeat (BITC) @(negedge clk);
      sp = sp & tx;
    end
  endtask

  task automatic test_reset();
    bus.rd_uart = 1'b0;
    bus.wr_uart = 1'b0;
    bus.clr_err = 1'b0;
    bus.w_data  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, bus.rx_empty, bus.tx_full, bus.tx_idle, bus.rx_ovf}
        !== 5'b11010) begin
      failures++;
      $display("FAIL reset_flags got=%b want=11010",
        {tx, bus.rx_empty, bus.tx_full, bus.tx_idle, bus.rx_ovf});
    end
    checks++;
    if ({bus.r_ferr, bus.r_perr, bus.r_data} !== 10'h000) begin
      failures++;
      $display("FAIL reset_rdata got=%h want=000",
        {bus.r_ferr, bus.r_perr, bus.r_data});
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_tx_a5();
    logic st, pb, sp;
    logic [7:0] d, e;
    bit ok;
    par_mode = 2'b00;
    stop2 = 1'b0;
    write_tx(8'hA5, 1'b1);
    tx_capture(st, d, pb, sp, ok);
    e = txq.pop_front();
    checks++;
    if (!ok || st !== 1'b0 || d !== e || sp !== 1'b1) begin
      failures++;
      $display("FAIL tx_a5 got ok=%0d st=%b d=%h sp=%b want st=0 d=%h sp=1",
        ok, st, d, sp, e);
    end
    checks++;
    if (bus.tx_idle !== 1'b0) begin
      failures++;
      $display("FAIL tx_idle_stop got=%b want=0", bus.tx_idle);
    end
    repeat (36) @(negedge clk);
    checks++;
    if (bus.tx_idle !== 1'b1 || tx !== 1'b1) begin
      failures++;
      $display("FAIL tx_idle_end got idle=%b tx=%b want 1 1",
        bus.tx_idle, tx);
    end
  endtask

  task automatic test_rx_parity();
    logic [9:0] w, e;
    bit ok;
    logic [1:0] pm [3];
    bit pbs [3];
    pm[0] = 2'b01; pbs[0] = 1'b1;
    pm[1] = 2'b01; pbs[1] = 1'b0;
    pm[2] = 2'b10; pbs[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      par_mode = pm[k];
      rx_frame(8'h07, pbs[k], 1'b1);
      read_rx(w, ok);
      e = rxq.pop_front();
      checks++;
      if (!ok || w !== e) begin
        failures++;
        $display("FAIL rx_parity%0d got ok=%0d w=%h want=%h", k, ok, w, e);
      end
    end
    par_mode = 2'b00;
  endtask

  task automatic test_rx_ferr();
    logic [9:0] w, e;
    bit ok;
    rx_frame(8'h3C, 1'b0, 1'b0);
    checks++;
    if (bus.rx_empty !== 1'b0 || bus.r_ferr !== 1'b1) begin
      failures++;
      $display("FAIL rx_ferr_flag got empty=%b ferr=%b want 0 1",
        bus.rx_empty, bus.r_ferr);
    end
    read_rx(w, ok);
    e = rxq.pop_front();
    checks++;
    if (!ok || w !== e) begin
      failures++;
      $display("FAIL rx_ferr_word got ok=%0d w=%h want=%h", ok, w, e);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (bus.rx_empty !== 1'b1) begin
      failures++;
      $display("FAIL rx_ferr_empty got=%b want=1", bus.rx_empty);
    end
  endtask

  task automatic test_rx_overrun();
    logic [9:0] w, e;
    bit ok;
    exp_ovf = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rx_frame(8'(8'h11 * (k + 1)), 1'b0, 1'b1);
      checks++;
      if (bus.rx_ovf !== exp_ovf) begin
        failures++;
        $display("FAIL rx_ovf_frame%0d got=%b want=%b",
          k, bus.rx_ovf, exp_ovf);
      end
    end
    for (int k = 0; k < 4; k++) begin
      read_rx(w, ok);
      e = rxq.pop_front();
      checks++;
      if (!ok || w !== e) begin
        failures++;
        $display("FAIL rx_ovf_word%0d got ok=%0d w=%h want=%h", k, ok, w, e);
      end
    end
    checks++;
    if (bus.rx_empty !== 1'b1 || bus.rx_ovf !== exp_ovf) begin
      failures++;
      $display("FAIL rx_ovf_drained got empty=%b ovf=%b want 1 %b",
        bus.rx_empty, bus.rx_ovf, exp_ovf);
    end
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    exp_ovf = 1'b0;
    checks++;
    if (bus.rx_ovf !== exp_ovf) begin
      failures++;
      $display("FAIL rx_ovf_clr got=%b want=%b", bus.rx_ovf, exp_ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic st, pb, sp;
    logic [7:0] d, e;
    bit ok;
    par_mode = 2'b10;
    stop2 = 1'b1;
    write_tx(8'h3A, 1'b1);
    write_tx(8'hC5, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tx_capture(st, d, pb, sp, ok);
      e = txq.pop_front();
      checks++;
      if (!ok || st !== 1'b0 || d !== e || pb !== ~(^e) || sp !== 1'b1) begin
        failures++;
        $display("FAIL b2b%0d got ok=%0d st=%b d=%h p=%b sp=%b want d=%h p=%b",
          k, ok, st, d, pb, sp, e, ~(^e));
      end
    end
    repeat (100) @(negedge clk);
    par_mode = 2'b00;
    stop2 = 1'b0;
  endtask

  task automatic test_tx_full();
    dvsr = 11'd0;
    for (int i = 0; i < 1023; i++) begin
      bus.w_data  = 8'(i);
      bus.wr_uart = 1'b1;
      @(negedge clk);
    end
    bus.wr_uart = 1'b0;
    checks++;
    if (bus.tx_full !== 1'b0 || bus.tx_idle !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL tx_1023 got full=%b idle=%b tx=%b want 0 0 1",
        bus.tx_full, bus.tx_idle, tx);
    end
    write_tx(8'hEE, 1'b0);
    checks++;
    if (bus.tx_full !== 1'b1) begin
      failures++;
      $display("FAIL tx_full got=%b want=1", bus.tx_full);
    end
    write_tx(8'hDD, 1'b0);
    checks++;
    if (bus.tx_full !== 1'b1 || tx !== 1'b1) begin
      failures++;
      $display("FAIL tx_full_hold got full=%b tx=%b want 1 1",
        bus.tx_full, tx);
    end
    apply_reset();
    checks++;
    if (bus.tx_full !== 1'b0 || bus.tx_idle !== 1'b1) begin
      failures++;
      $display("FAIL tx_full_reset got full=%b idle=%b want 0 1",
        bus.tx_full, bus.tx_idle);
    end
    dvsr = 11'd4;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic st, pb, sp;
    logic [7:0] d, e;
    logic [9:0] w, ew;
    bit ok;
    int n = 0;
    write_tx(8'h00, 1'b0);
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    rx = 1'b1;
    repeat (BITC) @(negedge clk);
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL mid_tx_busy got=%b want=0", tx);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({tx, bus.rx_empty, bus.tx_full, bus.tx_idle, bus.rx_ovf}
        !== 5'b11010 || {bus.r_ferr, bus.r_perr, bus.r_data} !== 10'h000) begin
      failures++;
      $display("FAIL mid_reset got=%b %h want=11010 000",
        {tx, bus.rx_empty, bus.tx_full, bus.tx_idle, bus.rx_ovf},
        {bus.r_ferr, bus.r_perr, bus.r_data});
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    rx_frame(8'h96, 1'b0, 1'b1);
    read_rx(w, ok);
    ew = rxq.pop_front();
    checks++;
    if (!ok || w !== ew) begin
      failures++;
      $display("FAIL post_reset_rx got ok=%0d w=%h want=%h", ok, w, ew);
    end
    write_tx(8'h69, 1'b1);
    tx_capture(st, d, pb, sp, ok);
    e = txq.pop_front();
    checks++;
    if (!ok || st !== 1'b0 || d !== e || sp !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_tx got ok=%0d d=%h want=%h", ok, d, e);
    end
    repeat (100) @(negedge clk);
  endtask

`ifdef UART_LOOPBACK_EN
  task automatic test_loopback();
    logic [9:0] w, e;
    logic [7:0] v [3];
    bit ok;
    v[0] = 8'h00; v[1] = 8'hFF; v[2] = 8'h5A;
    par_mode = 2'b10;
    stop2 = 1'b1;
    loopback = 1'b1;
    lb_low = 0;
    lb_watch = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rxq.push_back({2'b00, v[k]});
      write_tx(v[k], 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      read_rx(w, ok);
      e = rxq.pop_front();
      checks++;
      if (!ok || w !== e) begin
        failures++;
        $display("FAIL loopback%0d got ok=%0d w=%h want=%h", k, ok, w, e);
      end
    end
    repeat (300) @(negedge clk);
    lb_watch = 1'b0;
    checks++;
    if (lb_low != 0) begin
      failures++;
      $display("FAIL loopback_pin got low_cycles=%0d want=0", lb_low);
    end
    loopback = 1'b0;
    par_mode = 2'b00;
    stop2 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_tx_a5();
    test_rx_parity();
    test_rx_ferr();
    test_rx_overrun();
    test_back_to_back();
    test_tx_full();
    test_reset_midframe();
`ifdef UART_LOOPBACK_EN
    test_loopback();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
